// File: rtl/ov_pixel_capture.sv
// OV-series parallel camera capture: registers VSYNC/HREF/D, pairs bytes into RGB565 pixels,
// buffers them in a show-ahead FIFO. Optional OV_CAPTURE_DECIMATE_EN keeps even pixels/lines only.
module ov_pixel_capture #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LINE_CNT_W = 10
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cfg_done,
    input  logic                  enable,
    input  logic                  VSYNC,
    input  logic                  HREF,
    input  logic [7:0]            D,
    output logic [15:0]           pix_data,
    output logic                  pix_sof,
    output logic                  pix_sol,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  frame_done,
    output logic [LINE_CNT_W-1:0] line_count,
    output logic                  overflow
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWaitFrame, StCapture} state_e;

    state_e                state_q;
    logic                  vs_r, hr_r, vs_prev, hr_prev;
    logic [7:0]            d_r;
    logic                  vs_fall, vs_rise, hr_rise, capture, entering;
    logic                  phase_q, sof_pend_q, sol_pend_q, keep;
    logic [7:0]            hi_q;
    logic                  pend_valid_q, pend_sof_q, pend_sol_q;
    logic [15:0]           pend_data_q;
    logic [LINE_CNT_W-1:0] line_cnt_q;
    logic [17:0]           mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic                  full, pop, push, drop;
    logic [17:0]           head;

    assign vs_fall  = vs_prev & ~vs_r;
    assign vs_rise  = ~vs_prev & vs_r;
    assign hr_rise  = hr_r & ~hr_prev;
    assign capture  = (state_q == StCapture);
    assign entering = (state_q == StWaitFrame) & vs_fall;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            vs_r    <= 1'b0;
            hr_r    <= 1'b0;
            d_r     <= 8'h00;
            vs_prev <= 1'b0;
            hr_prev <= 1'b0;
        end else begin
            vs_r    <= VSYNC;
            hr_r    <= HREF;
            d_r     <= D;
            vs_prev <= vs_r;
            hr_prev <= hr_r;
        end
    end

    // Overflow clear on IDLE->WAIT_FRAME is placed after the set so it wins.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q    <= StIdle;
            frame_done <= 1'b0;
            line_count <= '0;
            line_cnt_q <= '0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (drop) overflow <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (cfg_done && enable) begin
                        state_q  <= StWaitFrame;
                        overflow <= 1'b0;
                    end
                end
                StWaitFrame: begin
                    if (vs_fall) begin
                        state_q    <= StCapture;
                        line_cnt_q <= '0;
                    end
                end
                StCapture: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        line_count <= line_cnt_q;
                        state_q    <= enable ? StWaitFrame : StIdle;
                    end else if (hr_rise && (line_cnt_q != '1)) begin
                        line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef OV_CAPTURE_DECIMATE_EN
    logic line_odd_q, pix_odd_q;

    assign keep = ~line_odd_q & ~pix_odd_q;

    // line_odd starts at 1 so the first HREF rise of the frame makes line 0 even.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            line_odd_q <= 1'b0;
            pix_odd_q  <= 1'b0;
        end else if (entering) begin
            line_odd_q <= 1'b1;
            pix_odd_q  <= 1'b0;
        end else if (capture) begin
            if (hr_rise) begin
                line_odd_q <= ~line_odd_q;
                pix_odd_q  <= 1'b0;
            end else if (hr_r && phase_q) begin
                pix_odd_q <= ~pix_odd_q;
            end
        end
    end
`else
    assign keep = 1'b1;
`endif

    // Assembled pixel is staged one cycle before the FIFO write.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            phase_q      <= 1'b0;
            hi_q         <= 8'h00;
            sof_pend_q   <= 1'b0;
            sol_pend_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 16'h0000;
            pend_sof_q   <= 1'b0;
            pend_sol_q   <= 1'b0;
        end else begin
            pend_valid_q <= 1'b0;
            if (entering) begin
                sof_pend_q <= 1'b1;
                sol_pend_q <= 1'b0;
                phase_q    <= 1'b0;
            end else if (capture) begin
                if (hr_rise) sol_pend_q <= 1'b1;
                if (!hr_r) begin
                    phase_q <= 1'b0;
                end else if (!phase_q) begin
                    hi_q    <= d_r;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    if (keep) begin
                        pend_valid_q <= 1'b1;
                        pend_data_q  <= {hi_q, d_r};
                        pend_sof_q   <= sof_pend_q;
                        pend_sol_q   <= sol_pend_q;
                        sof_pend_q   <= 1'b0;
                        sol_pend_q   <= 1'b0;
                    end
                end
            end else begin
                phase_q <= 1'b0;
            end
        end
    end

    assign full = (count_q == CntW'(FIFO_DEPTH));
    assign pop  = pix_valid & pix_ready;
    assign push = pend_valid_q & (~full | pop);
    assign drop = pend_valid_q & ~push;

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr_q] <= {pend_data_q, pend_sof_q, pend_sol_q};
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head      = mem[rd_ptr_q];
    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? head[17:2] : 16'h0000;
    assign pix_sof   = pix_valid & head[1];
    assign pix_sol   = pix_valid & head[0];
endmodule

// File: tb/tb_ov_pixel_capture.sv
// Scoreboard bench for ov_pixel_capture: a frame-level model queues expected pixels,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_ov_pixel_capture;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LINE_CNT_W = 10;
`ifdef OV_CAPTURE_DECIMATE_EN
    localparam bit Decim = 1'b1;
`else
    localparam bit Decim = 1'b0;
`endif

    logic PCLK = 1'b0, PRESETN = 1'b0, cfg_done = 1'b0, enable = 1'b0;
    logic VSYNC = 1'b0, HREF = 1'b0, pix_ready = 1'b0;
    logic [7:0] D = 8'h00;
    logic [15:0] pix_data;
    logic pix_sof, pix_sol, pix_valid, frame_done, overflow;
    logic [LINE_CNT_W-1:0] line_count;

    ov_pixel_capture #(.FIFO_DEPTH(FIFO_DEPTH), .LINE_CNT_W(LINE_CNT_W)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .cfg_done(cfg_done), .enable(enable),
        .VSYNC(VSYNC), .HREF(HREF), .D(D), .pix_data(pix_data), .pix_sof(pix_sof),
        .pix_sol(pix_sol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .line_count(line_count), .overflow(overflow)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {logic [15:0] data; logic sof; logic sol;} pix_t;
    pix_t exp_q[$];
    int   rise_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   pop_cnt = 0, valid_cnt = 0, fd_cnt = 0;
    logic [LINE_CNT_W-1:0] last_lc = '0;
    bit   prev_valid = 1'b0;
    bit   sb_off = 1'b0;
    int   ready_mode = 1;
    int   m_line = 0, m_keep_left = -1, g_byte = 0, lat_edge = 0, exp_pushed = 0;
    bit   m_sof_pend = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare the head whenever valid, pop on valid&ready.
    always @(negedge PCLK) begin
        if (PRESETN && !sb_off) begin
            if (pix_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %04h expected none", pix_data);
                end else begin
                    check("pixel", {14'b0, pix_data, pix_sof, pix_sol}, {14'b0, exp_q[0]});
                    if (pix_ready) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
        end
        if (pix_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid = pix_valid;
        if (frame_done) begin
            fd_cnt++;
            last_lc = line_count;
        end
    end

    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            pix_ready = (ready_mode == 2) ? ($urandom_range(7) != 0) : (ready_mode == 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic frame_start(input bit cap);
        m_line     = 0;
        m_sof_pend = cap;
        VSYNC = 1'b1;
        tick(4);
        VSYNC = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        HREF = 1'b0;
        tick(4);
        VSYNC = 1'b1;
        tick(4);
    endtask

    task automatic send_line(input int nbytes, input int pat, input bit cap, input int drop_at);
        logic [7:0] b[$];
        logic [7:0] v;
        bit first, kp;
        for (int i = 0; i < nbytes; i++) begin
            case (pat)
                0: begin v = 8'((18 + 34 * g_byte) % 256); g_byte++; end
                1: v = 8'($urandom_range(255));
                2: v = (i % 2 == 0) ? 8'(m_line) : 8'(i / 2);
                3: v = 8'(161 + i);
                default: v = 8'(177 + i);
            endcase
            b.push_back(v);
        end
        if (cap) begin
            first = 1'b1;
            for (int k = 0; k < nbytes / 2; k++) begin
                kp = Decim ? ((m_line % 2 == 0) && (k % 2 == 0)) : 1'b1;
                if (kp) begin
                    if (m_keep_left != 0) begin
                        exp_q.push_back({b[2*k], b[2*k+1], m_sof_pend, first});
                        exp_pushed++;
                        if (m_keep_left > 0) m_keep_left--;
                    end
                    m_sof_pend = 1'b0;
                    first = 1'b0;
                end
            end
        end
        for (int i = 0; i < nbytes; i++) begin
            HREF = 1'b1;
            D = b[i];
            if (i == drop_at) enable = 1'b0;
            if (m_line == 0 && i == 1) lat_edge = cyc + 1;
            tick();
        end
        m_line++;
        HREF = 1'b0;
        D = 8'($urandom_range(255));
        tick(4);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        tick(4);
        check("valid_after_drain", {31'b0, pix_valid}, 0);
    endtask

    int fd0, v0, p0, e0, r0, nl;

    initial begin
        // Reset with VSYNC toggling
        PRESETN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            VSYNC = ~VSYNC;
            tick();
        end
        check("reset_data", {15'b0, pix_data, pix_valid}, 0);
        check("reset_tags", {28'b0, pix_sof, pix_sol, frame_done, overflow}, 0);
        check("reset_line_count", 32'(line_count), 0);
        PRESETN = 1'b1;
        VSYNC = 1'b0;
        ready_mode = 1;
        tick(2);

        // cfg_done low: no capture
        enable = 1'b1;
        fd0 = fd_cnt; v0 = valid_cnt;
        frame_start(1'b0);
        for (int l = 0; l < 3; l++) send_line(6, 1, 1'b0, -1);
        frame_end();
        check("idle_frame_done", fd_cnt - fd0, 0);
        check("idle_no_valid", valid_cnt - v0, 0);
        check("idle_line_count", 32'(line_count), 0);

        // Basic 4x3 frame
        cfg_done = 1'b1;
        tick(2);
        g_byte = 0;
        fd0 = fd_cnt; p0 = pop_cnt; e0 = exp_pushed; r0 = rise_q.size();
        frame_start(1'b1);
        for (int l = 0; l < 4; l++) send_line(6, 0, 1'b1, -1);
        frame_end();
        drain();
        check("basic_frame_done", fd_cnt - fd0, 1);
        check("basic_line_count", 32'(last_lc), 4);
        check("basic_pixels", pop_cnt - p0, exp_pushed - e0);
        check("basic_pixels_abs", exp_pushed - e0, Decim ? 4 : 12);
        if (rise_q.size() > r0) check("basic_latency", rise_q[r0], lat_edge + 2);
        else check("basic_latency_seen", 0, 1);

        // Odd trailing byte
        fd0 = fd_cnt; p0 = pop_cnt; e0 = exp_pushed;
        frame_start(1'b1);
        send_line(5, 3, 1'b1, -1);
        send_line(4, 4, 1'b1, -1);
        frame_end();
        drain();
        check("odd_pixels", pop_cnt - p0, exp_pushed - e0);
        check("odd_line_count", 32'(last_lc), 2);

        // Random frames with random backpressure
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            nl = $urandom_range(5, 1);
            fd0 = fd_cnt; p0 = pop_cnt; e0 = exp_pushed;
            frame_start(1'b1);
            for (int l = 0; l < nl; l++) send_line($urandom_range(16, 2), 1, 1'b1, -1);
            frame_end();
            drain();
            check("rand_frame_done", fd_cnt - fd0, 1);
            check("rand_line_count", 32'(last_lc), nl);
            check("rand_pixels", pop_cnt - p0, exp_pushed - e0);
        end
        check("no_overflow_yet", {31'b0, overflow}, 0);

        // Backpressure / overflow
        ready_mode = 0;
        tick(2);
        m_keep_left = FIFO_DEPTH;
        p0 = pop_cnt;
        frame_start(1'b1);
        for (int l = 0; l < (Decim ? 3 : 1); l++) send_line(20, 1, 1'b1, -1);
        frame_end();
        check("overflow_set", {31'b0, overflow}, 1);
        check("overflow_held_valid", {31'b0, pix_valid}, 1);
        ready_mode = 1;
        drain();
        check("overflow_drain_count", pop_cnt - p0, FIFO_DEPTH);
        m_keep_left = -1;

        // Mid-frame disable: frame completes, then IDLE
        fd0 = fd_cnt; p0 = pop_cnt; e0 = exp_pushed;
        frame_start(1'b1);
        for (int l = 0; l < 4; l++) send_line(6, 1, 1'b1, (l == 2) ? 3 : -1);
        frame_end();
        drain();
        check("disable_frame_done", fd_cnt - fd0, 1);
        check("disable_line_count", 32'(last_lc), 4);
        check("disable_pixels", pop_cnt - p0, exp_pushed - e0);
        check("overflow_sticky", {31'b0, overflow}, 1);
        fd0 = fd_cnt; v0 = valid_cnt;
        frame_start(1'b0);
        for (int l = 0; l < 2; l++) send_line(6, 1, 1'b0, -1);
        frame_end();
        check("disabled_no_frame", fd_cnt - fd0, 0);
        check("disabled_no_valid", valid_cnt - v0, 0);
        enable = 1'b1;
        tick(3);
        check("overflow_cleared", {31'b0, overflow}, 0);

        // Reset mid-line
        sb_off = 1'b1;
        ready_mode = 0;
        fd0 = fd_cnt;
        frame_start(1'b0);
        send_line(6, 1, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            HREF = 1'b1;
            D = 8'($urandom_range(255));
            tick();
        end
        PRESETN = 1'b0;
        tick(2);
        PRESETN = 1'b1;
        check("reset_fifo_empty", {31'b0, pix_valid}, 0);
        check("reset_line_count_mid", 32'(line_count), 0);
        sb_off = 1'b0;
        ready_mode = 1;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            D = 8'($urandom_range(255));
            tick();
        end
        HREF = 1'b0;
        tick(4);
        send_line(6, 1, 1'b0, -1);
        frame_end();
        check("reset_no_resume", valid_cnt - v0, 0);
        check("reset_no_frame_done", fd_cnt - fd0, 0);
        fd0 = fd_cnt; p0 = pop_cnt; e0 = exp_pushed;
        frame_start(1'b1);
        for (int l = 0; l < 2; l++) send_line(8, 1, 1'b1, -1);
        frame_end();
        drain();
        check("resume_frame_done", fd_cnt - fd0, 1);
        check("resume_line_count", 32'(last_lc), 2);
        check("resume_pixels", pop_cnt - p0, exp_pushed - e0);

        // Decimation pattern P(l,p) = 0x0100*l + p
        fd0 = fd_cnt; p0 = pop_cnt; e0 = exp_pushed;
        frame_start(1'b1);
        for (int l = 0; l < 4; l++) send_line(8, 2, 1'b1, -1);
        frame_end();
        drain();
        check("decim_line_count", 32'(last_lc), 4);
        check("decim_pixels", pop_cnt - p0, exp_pushed - e0);
        check("decim_pixels_abs", exp_pushed - e0, Decim ? 4 : 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ov_pixel_capture.md
Name: ov_pixel_capture

Overview:
- Downstream consumer of the camera once config_sccb has programmed it.
- Samples the OV-series parallel video bus (VSYNC, HREF, D[7:0]) on the camera pixel clock and assembles byte pairs into RGB565 pixels.
- Buffers pixels in a small FIFO and presents them on a valid/ready stream to the frame-buffer / DMA stage.
- Gates capture on a configuration-done input and reports per-frame line counts and overflow.

Parameters:
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, 2..64.
- LINE_CNT_W, 10, width of line and pixel counters.

Ports:
- PCLK  input  1  camera pixel clock; single clock domain.
- PRESETN  input  1  reset, synchronous, active-low.
- cfg_done  input  1  high once SCCB configuration has completed; level.
- enable  input  1  capture enable; level.
- VSYNC  input  1  camera vertical sync; high = vertical blanking.
- HREF  input  1  camera line valid; high = active bytes on D.
- D  input  8  camera data byte.
- pix_data  output  16  RGB565 pixel, first byte in [15:8].
- pix_sof  output  1  tag: first pixel of frame.
- pix_sol  output  1  tag: first pixel of a line.
- pix_valid  output  1  FIFO head valid.
- pix_ready  input  1  consumer accepts the head this cycle.
- frame_done  output  1  one-cycle pulse at end of a captured frame.
- line_count  output  LINE_CNT_W  lines counted in the last completed frame.
- overflow  output  1  sticky; a pixel was dropped because the FIFO was full.

Behaviour:
- Clocking and reset:
  - Single clock domain, PCLK. Reset is synchronous, active-low on PRESETN.
  - Reset clears all outputs to 0, including pix_data, line_count and overflow. It also empties the FIFO and puts the FSM in IDLE.
- Input sampling: VSYNC, HREF and D are registered once. All decisions use the registered copies (vs_r, hr_r, d_r) plus their previous values for edge detection.
- FSM:
  - IDLE: waits for cfg_done=1 and enable=1, then goes to WAIT_FRAME.
  - WAIT_FRAME: on a falling edge of vs_r, goes to CAPTURE. This includes the case where VSYNC was already low on entry; the block waits for a full VSYNC high-then-low sequence.
  - CAPTURE: on a rising edge of vs_r, pulses frame_done for one cycle and latches line_count. Next state is WAIT_FRAME if enable=1, otherwise IDLE.
  - enable or cfg_done dropping mid-frame does not abort; the current frame completes.
- Byte assembly, in CAPTURE only:
  - A phase bit toggles on each cycle with hr_r=1 and is forced to 0 when hr_r=0.
  - Phase 0 stores d_r as the high byte. Phase 1 forms the pixel {hi, d_r} and pushes it.
  - An odd trailing byte at HREF fall is discarded.
- Tags:
  - pix_sol is set on the first pixel after a rising edge of hr_r.
  - pix_sof is set on the first pixel of the frame.
  - Tags are stored in the FIFO alongside the data.
- Line counter: increments on each hr_r rising edge in CAPTURE, resets to 0 on entry to CAPTURE, saturates at all-ones.
- Latency: second byte on D at edge N gives pix_valid=1 with that pixel at edge N+2, when the FIFO is empty.
- FIFO:
  - Show-ahead; pop when pix_valid and pix_ready are both high.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and overflow is set. overflow clears only on reset or on an IDLE→WAIT_FRAME transition.
  - pix_data and the tags are held stable while pix_valid=1 and pix_ready=0.
- Reset mid-frame: behaves as reset above. Capture re-synchronises to the next VSYNC falling edge; no partial pixel survives.

Optional Feature:
- Macro: OV_CAPTURE_DECIMATE_EN.
- When defined:
  - Only even pixels within a line (pixel index 0, 2, 4…) and even lines (0, 2…) are pushed, e.g. VGA 640x480 → QVGA 320x240.
  - pix_sol marks the first kept pixel of each kept line.
  - line_count still counts all lines.
- When undefined: every pixel and every line is pushed. No decimation counters exist.

Test Plan:
- Reset/idle:
  - Stimulus: PRESETN=0 for 3 cycles with VSYNC toggling; then cfg_done=0 with a full frame driven.
  - Required: all outputs 0, and pix_valid is never asserted.
- Basic frame:
  - Stimulus: cfg_done=1, enable=1, pix_ready=1; a 4-line frame of 3 pixels per line, bytes 0x12,0x34,0x56,0x78,…
  - Required: 12 pixels, the first 0x1234 with sof=1 and sol=1; sol=1 on pixels 0, 3, 6, 9; frame_done pulses once; line_count=4.
  - Required: first pix_valid appears 2 cycles after byte 0x34.
- Backpressure/overflow:
  - Stimulus: pix_ready=0 while 10 pixels arrive (FIFO_DEPTH=8).
  - Required: the first 8 pixels are retained in order, overflow=1, head stable.
  - Stimulus: then pix_ready=1.
  - Required: exactly 8 pixels drain.
- Odd byte:
  - Stimulus: a line of 5 bytes (0xA1..0xA5).
  - Required: pixels 0xA1A2 and 0xA3A4 are output; 0xA5 is discarded; the next line starts at phase 0.
- Mid-frame disable and reset:
  - Stimulus: drop enable during line 2.
  - Required: the frame completes, frame_done pulses, the FSM returns to IDLE, and no further pixels appear.
  - Stimulus: assert PRESETN=0 mid-line.
  - Required: FIFO empty, and capture resumes only after the next VSYNC high→low.
- Decimate (OV_CAPTURE_DECIMATE_EN):
  - Stimulus: 4 lines of 4 pixels, values P(l,p)=0x0100*l+p.
  - Required: output 0x0000, 0x0002, 0x0200, 0x0202; line_count=4.
